// File: rtl/gf180mcu_fd_sc_mcu7t5v0__rrarb3_1_pkg.sv
// Shared definitions for the three-requester round-robin arbiter.
// Holds the state encoding, reset constants and a grant-vector helper.
package gf180mcu_fd_sc_mcu7t5v0__rrarb3_1_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_t;

  // LAST resets to 3 so the first search after reset starts at requester 1.
  localparam logic [1:0] LAST_RESET   = 2'd3;
  localparam int         HOLD_MAX_MIN = 1;
  localparam int         HOLD_MAX_MAX = 255;

  function automatic logic [2:0] onehot3(input logic [1:0] idx);
    logic [2:0] v;
    v = 3'b000;
    case (idx)
      2'd1:    v = 3'b001;
      2'd2:    v = 3'b010;
      2'd3:    v = 3'b100;
      default: v = 3'b000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__or3_4.sv
// Three-input OR library cell, drive strength 4.
module gf180mcu_fd_sc_mcu7t5v0__or3_4 (
  input  logic A1,
  input  logic A2,
  input  logic A3,
  output logic Z
);

  assign Z = A1 | A2 | A3;

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__rrarb3_pick.sv
// Combinational round-robin picker: searches from LAST+1, wrapping 3 -> 1,
// and returns the first asserted request index (1..3) with a valid flag.
module gf180mcu_fd_sc_mcu7t5v0__rrarb3_pick (
  input  logic [1:0] last,
  input  logic [2:0] req,
  output logic [1:0] win,
  output logic       valid
);

  logic [1:0] idx;

  always_comb begin
    win   = 2'd0;
    valid = 1'b0;
    idx   = last;
    for (int k = 0; k < 3; k++) begin
      idx = (idx == 2'd3) ? 2'd1 : idx + 2'd1;
      if (!valid && req[idx - 2'd1]) begin
        win   = idx;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__rrarb3_1.sv
// Three-requester round-robin arbiter with bounded grant hold.
// Registered one-hot grant; Z is the raw OR of the requests.
module gf180mcu_fd_sc_mcu7t5v0__rrarb3_1
  import gf180mcu_fd_sc_mcu7t5v0__rrarb3_1_pkg::*;
#(
  parameter int HOLD_MAX = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic A1,
  input  logic A2,
  input  logic A3,
  output logic G1,
  output logic G2,
  output logic G3,
  output logic BUSY,
  output logic Z
);

  localparam int          CW      = $clog2(HOLD_MAX + 1);
  localparam logic [CW-1:0] CNT_SAT = CW'(HOLD_MAX - 1);

  if (HOLD_MAX < HOLD_MAX_MIN || HOLD_MAX > HOLD_MAX_MAX) begin : g_bad_hold_max
    $error("HOLD_MAX out of legal range");
  end

  arb_state_t    state_q, state_d;
  logic [1:0]    last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    grant_q, grant_d;
  logic          busy_q;

  logic [2:0] req;
  logic [2:0] holder_mask;
  logic       holder_req;
  logic [1:0] win;
  logic       win_valid;

  assign req         = {A3, A2, A1};
  assign holder_mask = (state_q == ST_OWN) ? onehot3(last_q) : 3'b000;
  assign holder_req  = |(req & holder_mask);

  gf180mcu_fd_sc_mcu7t5v0__or3_4 u_or3 (
    .A1 (A1),
    .A2 (A2),
    .A3 (A3),
    .Z  (Z)
  );

  // The holder is masked out, so in OWN the winner is always the next
  // requester after the holder; in IDLE the mask is empty.
  gf180mcu_fd_sc_mcu7t5v0__rrarb3_pick u_pick (
    .last  (last_q),
    .req   (req & ~holder_mask),
    .win   (win),
    .valid (win_valid)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          state_d = ST_OWN;
          last_d  = win;
          cnt_d   = '0;
          grant_d = onehot3(win);
        end
      end
      ST_OWN: begin
        // Hand over on release, or on preemption once the hold budget is spent.
        if (win_valid && (!holder_req || cnt_q == CNT_SAT)) begin
          last_d  = win;
          cnt_d   = '0;
          grant_d = onehot3(win);
        end else if (!holder_req) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          grant_d = 3'b000;
        end else if (cnt_q != CNT_SAT) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = 3'b000;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      last_q  <= LAST_RESET;
      cnt_q   <= '0;
      grant_q <= 3'b000;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      busy_q  <= |grant_d;
    end
  end

  assign G1   = grant_q[0];
  assign G2   = grant_q[1];
  assign G3   = grant_q[2];
  assign BUSY = busy_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__rrarb3_1.sv
// Self-checking bench for the round-robin arbiter: two instances
// (HOLD_MAX=8 and HOLD_MAX=1) compared against a behavioural owner model.
module tb_gf180mcu_fd_sc_mcu7t5v0__rrarb3_1;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic A1 = 1'b0, A2 = 1'b0, A3 = 1'b0;

  wire [2:0] g8, g1;
  wire       busy8, busy1, z8, z1;

  int tests_run    = 0;
  int tests_failed = 0;

  // Model: index 0 models HOLD_MAX=8, index 1 models HOLD_MAX=1.
  int holder[2];
  int last_m[2];
  int held[2];
  int hold_lim[2] = '{8, 1};

  always #5 CLK = ~CLK;

  gf180mcu_fd_sc_mcu7t5v0__rrarb3_1 #(.HOLD_MAX(8)) dut8 (
    .CLK(CLK), .RST(RST), .A1(A1), .A2(A2), .A3(A3),
    .G1(g8[0]), .G2(g8[1]), .G3(g8[2]), .BUSY(busy8), .Z(z8)
  );

  gf180mcu_fd_sc_mcu7t5v0__rrarb3_1 #(.HOLD_MAX(1)) dut1 (
    .CLK(CLK), .RST(RST), .A1(A1), .A2(A2), .A3(A3),
    .G1(g1[0]), .G2(g1[1]), .G3(g1[2]), .BUSY(busy1), .Z(z1)
  );

  function automatic int rr_next(input int start, input logic [2:0] r);
    for (int k = 1; k <= 3; k++) begin
      int cand;
      cand = ((start - 1 + k) % 3) + 1;
      if (r[cand-1]) return cand;
    end
    return 0;
  endfunction

  function automatic logic [2:0] exp_g(input int m);
    if (holder[m] == 0) return 3'b000;
    return 3'(1 << (holder[m] - 1));
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      holder[m] = 0;
      last_m[m] = 3;
      held[m]   = 0;
    end
  endtask

  task automatic model_step(input logic [2:0] r);
    for (int m = 0; m < 2; m++) begin
      int h, w;
      logic [2:0] others;
      h = holder[m];
      if (h == 0) begin
        w = rr_next(last_m[m], r);
        if (w != 0) begin
          holder[m] = w; last_m[m] = w; held[m] = 1;
        end
      end else begin
        others = r & ~(3'(1 << (h - 1)));
        if (!r[h-1] || (others != 3'b000 && held[m] >= hold_lim[m])) begin
          w = rr_next(h, others);
          if (w != 0) begin
            holder[m] = w; last_m[m] = w; held[m] = 1;
          end else begin
            holder[m] = 0; last_m[m] = h; held[m] = 0;
          end
        end else begin
          held[m]++;
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic [2:0] r);
    {A3, A2, A1} = r;
    @(posedge CLK);
    model_step(r);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    {A3, A2, A1} = 3'b000;
    model_reset();
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_reset();
    {A3, A2, A1} = 3'b000;
    #1 RST = 1'b1;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    tests_run++;
    if (g8 !== 3'b000 || busy8 !== 1'b0 || g1 !== 3'b000 || busy1 !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_state: g8=%b busy8=%b g1=%b busy1=%b, expected all 0", g8, busy8, g1, busy1);
    end
    {A3, A2, A1} = 3'b101;
    #1;
    tests_run++;
    if (z8 !== 1'b1 || z1 !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL z_in_reset: z8=%b z1=%b, expected 1", z8, z1);
    end
    {A3, A2, A1} = 3'b000;
    #1;
    tests_run++;
    if (z8 !== 1'b0 || z1 !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL z_in_reset_low: z8=%b z1=%b, expected 0", z8, z1);
    end
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_all_at_once();
    applyStimulus(3'b111);
    tests_run++;
    if (g8 !== 3'b001 || busy8 !== 1'b1 || z8 !== 1'b1 || g1 !== 3'b001 || busy1 !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL first_grant: g8=%b busy8=%b z8=%b g1=%b busy1=%b, expected g=001 busy=1 z=1",
               g8, busy8, z8, g1, busy1);
    end
  endtask

  task automatic test_two_holders();
    logic [2:0] want;
    do_reset();
    for (int c = 1; c <= 20; c++) begin
      applyStimulus(3'b011);
      want = (c >= 9 && c <= 16) ? 3'b010 : 3'b001;
      tests_run++;
      if (g8 !== want || busy8 !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL two_holders c=%0d: g8=%b busy8=%b, expected g8=%b busy8=1", c, g8, busy8, want);
      end
      tests_run++;
      if (g1 !== exp_g(1)) begin
        tests_failed++;
        $display("[TB] FAIL two_holders_h1 c=%0d: g1=%b, expected %b", c, g1, exp_g(1));
      end
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int c = 1; c <= 20; c++) begin
      applyStimulus(3'b010);
      tests_run++;
      if (g8 !== 3'b010 || g1 !== 3'b010) begin
        tests_failed++;
        $display("[TB] FAIL saturate c=%0d: g8=%b g1=%b, expected 010", c, g8, g1);
      end
    end
    // A long-held grant with a saturated counter yields at once to a newcomer.
    applyStimulus(3'b011);
    tests_run++;
    if (g8 !== 3'b001 || g8 !== exp_g(0)) begin
      tests_failed++;
      $display("[TB] FAIL saturate_preempt: g8=%b, expected 001", g8);
    end
  endtask

  task automatic test_release_handover();
    do_reset();
    applyStimulus(3'b100);
    applyStimulus(3'b101);
    tests_run++;
    if (g8 !== 3'b100) begin
      tests_failed++;
      $display("[TB] FAIL hold_g3: g8=%b, expected 100", g8);
    end
    applyStimulus(3'b001);
    tests_run++;
    if (g8 !== 3'b001 || busy8 !== 1'b1 || g1 !== 3'b001) begin
      tests_failed++;
      $display("[TB] FAIL release_handover: g8=%b busy8=%b g1=%b, expected 001 1 001", g8, busy8, g1);
    end
    applyStimulus(3'b000);
    tests_run++;
    if (g8 !== 3'b000 || busy8 !== 1'b0 || g1 !== 3'b000 || busy1 !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL release_idle: g8=%b busy8=%b g1=%b busy1=%b, expected 0", g8, busy8, g1, busy1);
    end
    // From idle with LAST=1, A2 and A3 pending: 2 comes next in order.
    applyStimulus(3'b110);
    tests_run++;
    if (g8 !== 3'b010) begin
      tests_failed++;
      $display("[TB] FAIL idle_rr_order: g8=%b, expected 010", g8);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    applyStimulus(3'b010);
    #2 RST = 1'b1;
    #1;
    model_reset();
    tests_run++;
    if (g8 !== 3'b000 || busy8 !== 1'b0 || g1 !== 3'b000 || busy1 !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL async_reset: g8=%b busy8=%b g1=%b busy1=%b, expected 0", g8, busy8, g1, busy1);
    end
    {A3, A2, A1} = 3'b110;
    @(negedge CLK);
    RST = 1'b0;
    applyStimulus(3'b110);
    tests_run++;
    if (g8 !== 3'b010 || g1 !== 3'b010) begin
      tests_failed++;
      $display("[TB] FAIL reset_rr_restart: g8=%b g1=%b, expected 010", g8, g1);
    end
  endtask

  task automatic test_hold_one();
    logic [2:0] seq [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    do_reset();
    for (int c = 0; c < 6; c++) begin
      applyStimulus(3'b111);
      tests_run++;
      if (g1 !== seq[c]) begin
        tests_failed++;
        $display("[TB] FAIL hold_one c=%0d: g1=%b, expected %b", c, g1, seq[c]);
      end
    end
    // Z follows the pins mid-cycle with no clock edge in between.
    {A3, A2, A1} = 3'b000;
    #1;
    tests_run++;
    if (z1 !== 1'b0 || z8 !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL z_comb_low: z1=%b z8=%b, expected 0", z1, z8);
    end
    {A3, A2, A1} = 3'b010;
    #1;
    tests_run++;
    if (z1 !== 1'b1 || z8 !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL z_comb_high: z1=%b z8=%b, expected 1", z1, z8);
    end
  endtask

  task automatic test_random();
    logic [2:0] r;
    do_reset();
    r = 3'b000;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 9) < 3) r = 3'($urandom_range(0, 7));
      applyStimulus(r);
      tests_run++;
      if (g8 !== exp_g(0) || busy8 !== (exp_g(0) != 3'b000) || z8 !== (|r)) begin
        tests_failed++;
        $display("[TB] FAIL random_h8 c=%0d req=%b: g8=%b busy8=%b z8=%b, expected g8=%b", c, r, g8, busy8, z8, exp_g(0));
      end
      tests_run++;
      if (g1 !== exp_g(1) || busy1 !== (exp_g(1) != 3'b000)) begin
        tests_failed++;
        $display("[TB] FAIL random_h1 c=%0d req=%b: g1=%b busy1=%b, expected g1=%b", c, r, g1, busy1, exp_g(1));
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_all_at_once();
    test_two_holders();
    test_saturate();
    test_release_handover();
    test_async_reset();
    test_hold_one();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
